fmap_buf_reader: RTL and testbench

//  Reads one finished feature map out of the conv output ping-pong buffers
//  (u_fmap_buff_01/02) through their port B and streams it downstream.

---
 rtl/fmap_buf_reader.sv | 149 ++++++++++++++
 tb/tb_fmap_buf_reader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_buf_reader.sv
// Streams one finished feature map out of the conv ping-pong buffers (port B) onto a valid/ready stream.
// Optional: define FMAP_RD_STALL_CNT_EN to add the stall_cnt backpressure counter port.
`timescale 1ns/1ps
module fmap_buf_reader #(
  parameter int W_DATA       = 128,
  parameter int FRAME_SIZE_W = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    rd_buff_sel,
  input  logic [FRAME_SIZE_W-1:0] num_pix,
  output logic                    busy,
  output logic                    done,
  output logic                    fmap_buf_enb01,
  output logic                    fmap_buf_enb02,
  output logic [FRAME_SIZE_W-1:0] fmap_buf_addrb,
  input  logic [W_DATA-1:0]       fmap_buf_dob01,
  input  logic [W_DATA-1:0]       fmap_buf_dob02,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [W_DATA-1:0]       m_data,
  output logic                    m_last
`ifdef FMAP_RD_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [FRAME_SIZE_W-1:0] ADDR_ONE = {{(FRAME_SIZE_W-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic                    sel_q;
  logic [FRAME_SIZE_W-1:0] num_q;
  logic [FRAME_SIZE_W-1:0] rd_addr;
  logic                    start_acc;
  logic                    issue;
  logic                    last_addr;
  logic                    pop;
  logic                    push;
  logic [2:0]              credit;

  logic                    vld_p1;
  logic                    last_p1;

  logic [W_DATA-1:0]       fifo_mem [0:1];
  logic [1:0]              fifo_lst;
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              fifo_cnt;

  assign start_acc = start && (state_q == S_IDLE);
  assign pop       = m_valid && m_ready;
  assign push      = vld_p1;
  assign last_addr = (rd_addr == (num_q - ADDR_ONE));

  // A new read is allowed only if the FIFO can still hold it after this cycle's pop.
  assign credit    = {1'b0, fifo_cnt} + {2'b00, vld_p1} - {2'b00, pop};
  assign issue     = (state_q == S_READ) && (credit < 3'd2);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (num_pix == '0) ? S_DONE : S_READ;
      S_READ:  if (issue && last_addr) state_d = S_DRAIN;
      // The last-tagged pop empties the FIFO with nothing left in flight.
      S_DRAIN: if (pop && m_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      num_q   <= '0;
      rd_addr <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        sel_q   <= rd_buff_sel;
        num_q   <= num_pix;
        rd_addr <= '0;
      end else if (issue) begin
        rd_addr <= rd_addr + ADDR_ONE;
      end
    end
  end

  // p1: read issued last cycle, dob valid now
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= issue;
      last_p1 <= issue && last_addr;
    end
  end

  // p2: skid FIFO, head drives the stream
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_lst    <= 2'b00;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= sel_q ? fmap_buf_dob02 : fmap_buf_dob01;
        fifo_lst[wr_ptr] <= last_p1;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign busy           = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);
  assign fmap_buf_enb01 = issue && !sel_q;
  assign fmap_buf_enb02 = issue && sel_q;
  assign fmap_buf_addrb = rd_addr;
  assign m_valid        = (fifo_cnt != 2'd0);
  assign m_data         = fifo_mem[rd_ptr];
  assign m_last         = fifo_lst[rd_ptr];

`ifdef FMAP_RD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if (m_valid && !m_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fmap_buf_reader.sv
// Directed bench for fmap_buf_reader: frame-level model plus a per-cycle compare process.
`timescale 1ns/1ps
module tb_fmap_buf_reader;
  localparam int W_DATA = 128;
  localparam int FW     = 16;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              rd_buff_sel = 1'b0;
  logic [FW-1:0]     num_pix = '0;
  logic              busy, done, enb01, enb02;
  logic [FW-1:0]     addrb;
  logic [W_DATA-1:0] dob01 = '0;
  logic [W_DATA-1:0] dob02 = '0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [W_DATA-1:0] m_data;
  logic              m_last;
`ifdef FMAP_RD_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  always #5 clk = ~clk;

  fmap_buf_reader #(.W_DATA(W_DATA), .FRAME_SIZE_W(FW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .rd_buff_sel(rd_buff_sel), .num_pix(num_pix),
    .busy(busy), .done(done), .fmap_buf_enb01(enb01), .fmap_buf_enb02(enb02),
    .fmap_buf_addrb(addrb), .fmap_buf_dob01(dob01), .fmap_buf_dob02(dob02),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
`ifdef FMAP_RD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Buffer 01 holds the address, buffer 02 the address tagged with B2 in the top byte.
  function automatic logic [W_DATA-1:0] pix_val(input logic sel, input logic [FW-1:0] a);
    logic [W_DATA-1:0] v;
    v = W_DATA'(a);
    if (sel) v[W_DATA-1 -: 8] = 8'hB2;
    return v;
  endfunction

  // Port-B read model: one-cycle registered read
  always @(posedge clk) begin
    if (enb01) dob01 <= pix_val(1'b0, addrb);
    if (enb02) dob02 <= pix_val(1'b1, addrb);
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic chkd(input string name, input logic [W_DATA-1:0] act, input logic [W_DATA-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Frame-level model state
  bit                m_busy = 1'b0;
  bit                exp_done = 1'b0;
  bit                m_sel = 1'b0;
  int                m_n = 0;
  int                m_idx = 0;
  int                issued = 0;
  int                hs_cnt = 0;
  int                done_cnt = 0;
  int                cyc = 0;
  int                start_neg = 0;
  int                first_valid_neg = -1;
  int                first_hs_neg = -1;
  int                last_hs_neg = -1;
  int                lat_done = -1;
  bit                prev_stall = 1'b0;
  logic [W_DATA-1:0] prev_data = '0;
  logic [W_DATA-1:0] first_data = '0;
  logic [W_DATA-1:0] last_data = '0;

  always @(negedge clk) begin
    bit exp_done_n;
    cyc++;
    if (!rstn) begin
      chk("reset_ctrl", 32'({busy, done, enb01, enb02, m_valid, m_last}), 32'd0);
      chk("reset_addrb", 32'(addrb), 32'd0);
      chkd("reset_data", m_data, '0);
      m_busy     = 1'b0;
      exp_done   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("fifo_cnt_le2", 32'(dut.fifo_cnt <= 2'd2), 32'd1);
      if (exp_done) begin
        done_cnt++;
        lat_done = cyc - start_neg;
        chk("pix_count", 32'(hs_cnt), 32'(m_n));
      end
      if (!m_busy) begin
        chk("enb_idle", 32'({enb01, enb02}), 32'd0);
        chk("valid_idle", 32'(m_valid), 32'd0);
      end else begin
        chk("enb_unsel", 32'(m_sel ? enb01 : enb02), 32'd0);
        if (m_sel ? enb02 : enb01) begin
          chk("addrb", 32'(addrb), 32'(issued));
          chk("over_issue", 32'(issued < m_n), 32'd1);
          issued++;
        end
        if (prev_stall) chk("hold_valid", 32'(m_valid), 32'd1);
        if (m_valid) begin
          if (first_valid_neg < 0) first_valid_neg = cyc;
          chkd("data", m_data, pix_val(m_sel, FW'(m_idx)));
          chk("last", 32'(m_last), 32'(m_idx == m_n - 1));
          if (prev_stall) chkd("hold_data", m_data, prev_data);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;

      exp_done_n = 1'b0;
      if (m_busy && m_valid && m_ready) begin
        if (first_hs_neg < 0) first_hs_neg = cyc;
        last_hs_neg = cyc;
        if (m_idx == 0) first_data = m_data;
        last_data = m_data;
        hs_cnt++;
        m_idx++;
        if (m_idx == m_n) begin
          exp_done_n = 1'b1;
          m_busy     = 1'b0;
        end
      end
      if (start && !m_busy && !exp_done) begin
        m_sel           = rd_buff_sel;
        m_n             = int'(num_pix);
        m_idx           = 0;
        hs_cnt          = 0;
        issued          = 0;
        start_neg       = cyc;
        first_valid_neg = -1;
        first_hs_neg    = -1;
        last_hs_neg     = -1;
        if (num_pix == '0) exp_done_n = 1'b1;
        else m_busy = 1'b1;
      end
      exp_done = exp_done_n;
    end
  end

  task automatic pulse_start(input logic sel, input int n);
    rd_buff_sel = sel;
    num_pix     = FW'(n);
    start       = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle, input string name);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge clk); #1;
      if (toggle) m_ready = ~m_ready;
      k++;
    end
    chk({name, "_timeout"}, 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    int k;
    idle(3);
    rstn = 1'b1;
    idle(2);

    // T1: buffer 01, 16 pixels at full rate
    d0 = done_cnt;
    m_ready = 1'b1;
    pulse_start(1'b0, 16);
    wait_done(100, 1'b0, "t1");
    idle(4);
    chk("t1_latency", 32'(first_valid_neg - start_neg), 32'd3);
    chk("t1_span", 32'(last_hs_neg - first_hs_neg), 32'd15);
    chk("t1_count", 32'(hs_cnt), 32'd16);
    chkd("t1_first", first_data, 128'd0);
    chkd("t1_lastdata", last_data, 128'd15);
    chk("t1_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t1_done_lat", 32'(lat_done - last_hs_neg + start_neg), 32'd1);

    // T2: buffer 02, 8 pixels, ready toggling
    m_ready = 1'b1;
    pulse_start(1'b1, 8);
    wait_done(200, 1'b1, "t2");
    m_ready = 1'b1;
    idle(3);
    chk("t2_count", 32'(hs_cnt), 32'd8);
    chkd("t2_first", first_data, {8'hB2, 120'd0});
    chkd("t2_lastdata", last_data, {8'hB2, 120'd7});

    // T3: empty frame
    d0 = done_cnt;
    pulse_start(1'b0, 0);
    wait_done(10, 1'b0, "t3");
    idle(3);
    chk("t3_done_lat", 32'(lat_done), 32'd1);
    chk("t3_no_valid", 32'(first_valid_neg), 32'hFFFF_FFFF);
    chk("t3_done_once", 32'(done_cnt - d0), 32'd1);

    // T4: second start mid-frame is ignored
    d0 = done_cnt;
    pulse_start(1'b0, 32);
    idle(5);
    pulse_start(1'b1, 5);
    wait_done(200, 1'b0, "t4");
    idle(10);
    chk("t4_count", 32'(hs_cnt), 32'd32);
    chkd("t4_lastdata", last_data, 128'd31);
    chk("t4_done_once", 32'(done_cnt - d0), 32'd1);

    // T5: async reset mid-frame, then a clean restart
    d0 = done_cnt;
    pulse_start(1'b0, 20);
    k = 0;
    while (hs_cnt < 5 && k < 100) begin @(posedge clk); #1; k++; end
    chk("t5_reach5", 32'(hs_cnt >= 5), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("t5_async_ctrl", 32'({busy, done, enb01, enb02, m_valid, m_last}), 32'd0);
    chkd("t5_async_data", m_data, '0);
    idle(2);
    rstn = 1'b1;
    idle(3);
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
    pulse_start(1'b0, 4);
    wait_done(50, 1'b0, "t5");
    idle(3);
    chk("t5_count", 32'(hs_cnt), 32'd4);
    chkd("t5_lastdata", last_data, 128'd3);

`ifdef FMAP_RD_STALL_CNT_EN
    // T6: seven stalled cycles right after the first valid
    m_ready = 1'b0;
    pulse_start(1'b0, 10);
    k = 0;
    while (!m_valid && k < 20) begin @(posedge clk); #1; k++; end
    chk("t6_valid_seen", 32'(m_valid), 32'd1);
    repeat (7) @(posedge clk);
    #1 m_ready = 1'b1;
    wait_done(100, 1'b0, "t6");
    idle(3);
    chk("t6_stall_cnt", stall_cnt, 32'd7);
    chk("t6_count", 32'(hs_cnt), 32'd10);
`endif

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
